mmio_bus_arbiter: RTL and testbench
===================================

Name: mmio_bus_arbiter

Overview:
- Two-master arbiter in front of the single MMIO peripheral slave. Master 0 is the CPU memory controller MMIO port; master 1 is a debug/DMA bridge.
- Round-robin grant, one outstanding transaction at a time, request fields latched for the whole transfer.
- Slave-side timeout so a stalled slave cannot hang a master; a UART TX write held off while the transmitter is busy is the typical stall case.
- Sits between the masters and the slave's mmio_valid/mmio_ready port; the slave protocol is unchanged.

Parameters:
- TIMEOUT_CYCLES, 4096, BUSY cycles without s_ready before the transfer is aborted (must be >= 2).
- ERR_RDATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- mN_valid  input  1  master N request (N = 0, 1); held high until mN_ready
- mN_write  input  1  1 = write, 0 = read
- mN_addr  input  32  byte address
- mN_wdata  input  32  write data
- mN_wstrb  input  4  byte strobes
- mN_rdata  output  32  read data; valid while mN_ready = 1
- mN_ready  output  1  one-cycle completion pulse
- mN_err  output  1  one-cycle pulse together with mN_ready when the transfer timed out
- s_valid, s_write, s_addr, s_wdata, s_wstrb  output  1/1/32/32/4  request to slave (registered)
- s_rdata  input  32  slave read data
- s_ready  input  1  slave completion pulse
- grant_id  output  1  master owning the current or most recent transfer
- busy  output  1  high in BUSY and DONE
- timeout_count  output  8  saturating count of timeouts

Behaviour:
- All outputs are registered.
- Reset value of every output and internal register is 0, except last_grant = 1, so master 0 wins the first tie.
- States:
  - IDLE → BUSY when any mN_valid is high. Select the master; latch write/addr/wdata/wstrb into s_*; set s_valid = 1, grant_id, last_grant; clear the timeout counter.
  - BUSY → DONE on s_ready. Set s_valid = 0, mN_rdata = s_rdata (0 for writes), mN_ready = 1 for the granted master only.
  - BUSY → DONE on timeout (counter reaches TIMEOUT_CYCLES-1 with s_ready low). Set s_valid = 0, mN_ready = 1, mN_err = 1, mN_rdata = ERR_RDATA (reads), timeout_count += 1, saturating at 255.
  - DONE → IDLE unconditionally after 1 cycle. All requests are ignored in DONE, giving the master time to drop valid.
- Arbitration:
  - Only one master valid → grant it.
  - Both valid → grant !last_grant (strict alternation).
- Latency: mN_valid seen in cycle t gives s_valid at t+1. A zero-wait slave raises s_ready at t+2, which gives mN_ready at t+3 and IDLE at t+4.
  - Sustained throughput: one transfer per 4 cycles.
- Ready pulses last exactly 1 cycle; m0_ready and m1_ready are never high together.
- mN_valid dropping during BUSY is a protocol violation. The transfer completes anyway from the latched fields; ready is still pulsed.
- s_ready outside BUSY (a late ack after a timeout) is ignored: no ready pulse, no state change.
- s_ready in the same cycle the counter expires → normal completion. Success wins; no err.
- s_* outputs hold their latched values through BUSY. s_valid is low in IDLE and DONE.
- Reset asserted mid-transfer → IDLE next clock. The in-flight transfer is dropped with no ready pulse, and s_valid is low.
- Timeout counter width is $clog2(TIMEOUT_CYCLES); it counts only in BUSY.

Decomposition:
- Shared include mmio_arb_defs.vh: state encodings (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2) and the default ERR_RDATA.
- Sub-module mmio_rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_id.
  - Instantiated once.
- The FSM, latching, timeout counter and response muxing live in mmio_bus_arbiter.

Test Plan:
- m0 read 0x8000000C, slave acks 1 cycle after s_valid with rdata 0x1 → s_addr = 0x8000000C at t+1; m0_ready = 1 and m0_rdata = 0x1 at t+3; m1_ready stays 0.
- m0 and m1 both valid from reset (m0 write 0x80000010 = 0x3, m1 read 0x80000018) → order m0, m1, m0, m1; grant_id toggles; each completion is 4 cycles apart.
- m1 write 0x80000000 with s_ready held low (TIMEOUT_CYCLES = 16) → m1_ready = 1 and m1_err = 1 on the 16th BUSY cycle; timeout_count = 1. A s_ready injected 2 cycles later is ignored.
- Read timeout → m0_rdata = 0xDEADBEEF with m0_err = 1. Repeat 300 timeouts → timeout_count saturates at 255.
- s_ready coincident with the final timeout cycle → normal completion, err = 0, timeout_count unchanged.
- resetn low for 1 cycle while BUSY → next cycle s_valid = 0, busy = 0, no mN_ready pulse. A subsequent m1-only request is granted normally.

Source files
------------

// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared types and constants for the two-master MMIO arbiter.
// Imported by the arbiter top; the picker is stand-alone combinational logic.
package mmio_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

    // Request fields captured at grant time and held for the whole transfer.
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mmio_req_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// MMIO valid/ready bus. The err line runs only from the arbiter to its
// masters; the peripheral never drives it, so the master modport omits it.
interface mmio_bus_arbiter_if;
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output valid, write, addr, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, write, addr, wdata, wstrb,
        output rdata, ready, err
    );
endinterface

// File: rtl/mmio_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins outright,
// a tie goes to the master that did not win last time.
module mmio_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        gnt_valid = |req;
        gnt_id    = 1'b0;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single MMIO slave, one
// transfer in flight, with a slave-side timeout that answers with an error.
module mmio_bus_arbiter
    import mmio_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic                      clk,
    input  logic                      resetn,
    mmio_bus_arbiter_if.slave         m0,
    mmio_bus_arbiter_if.slave         m1,
    mmio_bus_arbiter_if.master        s,
    output logic                      grant_id,
    output logic                      busy,
    output logic [7:0]                timeout_count
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state;
    mmio_req_t        req_q;
    mmio_req_t        pick_req;
    logic             s_valid_q;
    logic             grant_q;
    logic             last_grant;
    logic             busy_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0]       tmo_total;
    logic [1:0]       ready_q;
    logic [1:0]       err_q;
    logic [31:0]      rdata_q [2];
    logic             gnt_valid;
    logic             gnt_id;

    mmio_rr_pick2 u_pick (
        .req        ({m1.valid, m0.valid}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        pick_req = '0;
        if (gnt_id) begin
            pick_req = '{write: m1.write, addr: m1.addr, wdata: m1.wdata, wstrb: m1.wstrb};
        end else begin
            pick_req = '{write: m0.write, addr: m0.addr, wdata: m0.wdata, wstrb: m0.wstrb};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking throughout so every register samples pre-edge values.
        if (!resetn) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            s_valid_q  <= 1'b0;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
            busy_q     <= 1'b0;
            tmo_cnt    <= '0;
            tmo_total  <= '0;
            ready_q    <= '0;
            err_q      <= '0;
            // NOTE: the two response-data words are reset like any other
            // register because they drive module outputs directly.
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            ready_q <= '0;
            err_q   <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        state      <= ST_BUSY;
                        req_q      <= pick_req;
                        s_valid_q  <= 1'b1;
                        grant_q    <= gnt_id;
                        last_grant <= gnt_id;
                        busy_q     <= 1'b1;
                        tmo_cnt    <= '0;
                    end
                end
                ST_BUSY: begin
                    // A slave ack in the expiry cycle still counts as success.
                    if (s.ready) begin
                        state            <= ST_DONE;
                        s_valid_q        <= 1'b0;
                        ready_q[grant_q] <= 1'b1;
                        rdata_q[grant_q] <= req_q.write ? 32'h0 : s.rdata;
                    end else if (tmo_cnt == CNT_LAST) begin
                        state            <= ST_DONE;
                        s_valid_q        <= 1'b0;
                        ready_q[grant_q] <= 1'b1;
                        err_q[grant_q]   <= 1'b1;
                        rdata_q[grant_q] <= req_q.write ? 32'h0 : ERR_RDATA;
                        tmo_total        <= sat_inc8(tmo_total);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    s_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign s.valid       = s_valid_q;
    assign s.write       = req_q.write;
    assign s.addr        = req_q.addr;
    assign s.wdata       = req_q.wdata;
    assign s.wstrb       = req_q.wstrb;

    assign m0.ready      = ready_q[0];
    assign m0.err        = err_q[0];
    assign m0.rdata      = rdata_q[0];
    assign m1.ready      = ready_q[1];
    assign m1.err        = err_q[1];
    assign m1.rdata      = rdata_q[1];

    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign timeout_count = tmo_total;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter: a per-cycle vector table for the
// single-read and contention sequences, then hand-written timeout/reset cases.
module tb_mmio_bus_arbiter;

    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       grant_id;
    logic       busy;
    logic [7:0] timeout_count;

    mmio_bus_arbiter_if m0_bus ();
    mmio_bus_arbiter_if m1_bus ();
    mmio_bus_arbiter_if s_bus ();

    mmio_bus_arbiter #(
        .TIMEOUT_CYCLES (TMO),
        .ERR_RDATA      (32'hDEADBEEF)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .m0            (m0_bus),
        .m1            (m1_bus),
        .s             (s_bus),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs are changed and outputs sampled on the falling edge.
    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic drive_master(input int mid, input logic v, input logic wr,
                                input logic [31:0] a, input logic [31:0] d);
        if (mid == 0) begin
            m0_bus.valid = v; m0_bus.write = wr; m0_bus.addr = a;
            m0_bus.wdata = d; m0_bus.wstrb = 4'hF;
        end else begin
            m1_bus.valid = v; m1_bus.write = wr; m1_bus.addr = a;
            m1_bus.wdata = d; m1_bus.wstrb = 4'hF;
        end
    endtask

    // One complete transfer from IDLE; ack_at = BUSY-cycle index of s_ready
    // (1 = first BUSY cycle), or -1 for a slave that never answers.
    task automatic do_xfer(input int mid, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_at, input logic [31:0] ack_data,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output logic other, output logic [68:0] s_snap);
        int k;
        drive_master(mid, 1'b1, wr, addr, wdata);
        cycle();
        k      = 1;
        other  = 1'b0;
        s_snap = {s_bus.write, s_bus.addr, s_bus.wdata, s_bus.wstrb};
        while (!((mid == 1) ? m1_bus.ready : m0_bus.ready) && k < 64) begin
            if ((mid == 1) ? (m0_bus.ready | m0_bus.err) : (m1_bus.ready | m1_bus.err)) other = 1'b1;
            s_bus.ready = (k == ack_at);
            s_bus.rdata = (k == ack_at) ? ack_data : 32'h0BAD0BAD;
            cycle();
            k++;
        end
        s_bus.ready = 1'b0;
        lat   = k;
        rdata = (mid == 1) ? m1_bus.rdata : m0_bus.rdata;
        err   = (mid == 1) ? m1_bus.err : m0_bus.err;
        if ((mid == 1) ? (m0_bus.ready | m0_bus.err) : (m1_bus.ready | m1_bus.err)) other = 1'b1;
        drive_master(mid, 1'b0, wr, addr, wdata);
        cycle();
    endtask

    typedef struct {
        logic        rstn, m0v, m0w;
        logic [31:0] m0a;
        logic        m1v, sr;
        logic [31:0] srd;
        logic        sv, sw;
        logic [31:0] sa;
        logic        gid, bsy, r0, r1;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic rstn, input logic m0v, input logic m0w,
                                input logic [31:0] m0a, input logic m1v, input logic sr,
                                input logic [31:0] srd, input logic sv, input logic sw,
                                input logic [31:0] sa, input logic gid, input logic bsy,
                                input logic r0, input logic r1, input logic [31:0] rd);
        vec_t v;
        v.rstn = rstn; v.m0v = m0v; v.m0w = m0w; v.m0a = m0a; v.m1v = m1v;
        v.sr = sr; v.srd = srd; v.sv = sv; v.sw = sw; v.sa = sa;
        v.gid = gid; v.bsy = bsy; v.r0 = r0; v.r1 = r1; v.rd = rd;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [23];
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic        other;
        logic [68:0] snap;
        logic        stray;
        int          bad;
        int          exp_cnt;

        localparam logic [31:0] A0C = 32'h8000000C;
        localparam logic [31:0] A10 = 32'h80000010;
        localparam logic [31:0] A18 = 32'h80000018;

        // Rows 0-4: m0 read with one-cycle slave; row 5 reset; rows 6-22: both
        // masters requesting continuously, grants alternate m0,m1,m0,m1.
        vecs[0]  = mk(1,1,0,A0C,0,0,0,            0,0,0,  0,0,0,0,0);
        vecs[1]  = mk(1,1,0,A0C,0,0,0,            1,0,A0C,0,1,0,0,0);
        vecs[2]  = mk(1,1,0,A0C,0,1,32'h1,        1,0,A0C,0,1,0,0,0);
        vecs[3]  = mk(1,0,0,A0C,0,0,0,            0,0,0,  0,1,1,0,32'h1);
        vecs[4]  = mk(1,0,0,A0C,0,0,0,            0,0,0,  0,0,0,0,0);
        vecs[5]  = mk(0,0,0,A0C,0,0,0,            0,0,0,  0,0,0,0,0);
        vecs[6]  = mk(1,1,1,A10,1,0,0,            0,0,0,  0,0,0,0,0);
        vecs[7]  = mk(1,1,1,A10,1,0,0,            1,1,A10,0,1,0,0,0);
        vecs[8]  = mk(1,1,1,A10,1,1,32'h55,       1,1,A10,0,1,0,0,0);
        vecs[9]  = mk(1,1,1,A10,1,0,0,            0,0,0,  0,1,1,0,0);
        vecs[10] = mk(1,1,1,A10,1,0,0,            0,0,0,  0,0,0,0,0);
        vecs[11] = mk(1,1,1,A10,1,0,0,            1,0,A18,1,1,0,0,0);
        vecs[12] = mk(1,1,1,A10,1,1,32'hA5A50001, 1,0,A18,1,1,0,0,0);
        vecs[13] = mk(1,1,1,A10,1,0,0,            0,0,0,  1,1,0,1,32'hA5A50001);
        vecs[14] = mk(1,1,1,A10,1,0,0,            0,0,0,  1,0,0,0,0);
        vecs[15] = mk(1,1,1,A10,1,0,0,            1,1,A10,0,1,0,0,0);
        vecs[16] = mk(1,1,1,A10,1,1,32'h77,       1,1,A10,0,1,0,0,0);
        vecs[17] = mk(1,1,1,A10,1,0,0,            0,0,0,  0,1,1,0,0);
        vecs[18] = mk(1,1,1,A10,1,0,0,            0,0,0,  0,0,0,0,0);
        vecs[19] = mk(1,1,1,A10,1,0,0,            1,0,A18,1,1,0,0,0);
        vecs[20] = mk(1,1,1,A10,1,1,32'h2,        1,0,A18,1,1,0,0,0);
        vecs[21] = mk(1,0,1,A10,0,0,0,            0,0,0,  1,1,0,1,32'h2);
        vecs[22] = mk(1,0,1,A10,0,0,0,            0,0,0,  1,0,0,0,0);

        resetn = 1'b0;
        drive_master(0, 1'b0, 1'b0, 32'h0, 32'h3);
        drive_master(1, 1'b0, 1'b0, A18, 32'h0);
        s_bus.ready = 1'b0;
        s_bus.rdata = 32'h0;
        s_bus.err   = 1'b0;
        cycle();
        cycle();
        resetn = 1'b1;
        check("reset_state", {grant_id, busy, timeout_count, s_bus.valid, m0_bus.ready, m1_bus.ready,
                              m0_bus.err, m1_bus.err, m0_bus.rdata, m1_bus.rdata}, '0);

        for (int i = 0; i < 23; i++) begin
            logic [31:0] obs_rd;
            obs_rd = vecs[i].r0 ? m0_bus.rdata : (vecs[i].r1 ? m1_bus.rdata : 32'h0);
            check($sformatf("vec%0d", i),
                  {s_bus.valid, (vecs[i].sv ? s_bus.write : 1'b0), (vecs[i].sv ? s_bus.addr : 32'h0),
                   grant_id, busy, m0_bus.ready, m1_bus.ready, m0_bus.err, m1_bus.err, obs_rd},
                  {vecs[i].sv, vecs[i].sw, vecs[i].sa, vecs[i].gid, vecs[i].bsy,
                   vecs[i].r0, vecs[i].r1, 2'b00, vecs[i].rd});
            resetn       = vecs[i].rstn;
            m0_bus.valid = vecs[i].m0v;
            m0_bus.write = vecs[i].m0w;
            m0_bus.addr  = vecs[i].m0a;
            m1_bus.valid = vecs[i].m1v;
            s_bus.ready  = vecs[i].sr;
            s_bus.rdata  = vecs[i].srd;
            cycle();
        end
        m0_bus.valid = 1'b0;
        m1_bus.valid = 1'b0;
        s_bus.ready  = 1'b0;

        // m1 write against a slave that never answers.
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        cycle();
        do_xfer(1, 1'b1, 32'h80000000, 32'h12345678, -1, 32'h0, lat, rdata, err, other, snap);
        check("wr_tmo_s_fields", snap, {1'b1, 32'h80000000, 32'h12345678, 4'hF});
        check("wr_tmo_latency", lat, 17);
        check("wr_tmo_err", {err, other}, 2'b10);
        check("wr_tmo_rdata", rdata, 32'h0);
        check("wr_tmo_count", timeout_count, 8'd1);

        // Late ack two cycles after the error pulse must be ignored.
        cycle();
        s_bus.ready = 1'b1;
        cycle();
        s_bus.ready = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stray |= m0_bus.ready | m1_bus.ready | busy | s_bus.valid;
            cycle();
        end
        check("late_ack_ignored", {stray, timeout_count}, {1'b0, 8'd1});

        do_xfer(0, 1'b0, 32'h80000004, 32'h0, -1, 32'h0, lat, rdata, err, other, snap);
        check("rd_tmo_rdata", rdata, 32'hDEADBEEF);
        check("rd_tmo_err_lat", {err, other, 8'(lat)}, {2'b10, 8'd17});
        check("rd_tmo_count", timeout_count, 8'd2);

        // Ack in the final counting cycle: success wins.
        do_xfer(0, 1'b0, 32'h80000008, 32'h0, TMO, 32'h600DF00D, lat, rdata, err, other, snap);
        check("coincident_ok", {err, other, 8'(lat), rdata}, {2'b00, 8'd17, 32'h600DF00D});
        check("coincident_count", timeout_count, 8'd2);

        bad     = 0;
        exp_cnt = 2;
        for (int i = 0; i < 300; i++) begin
            do_xfer(i % 2, 1'b0, 32'h80000030, 32'h0, -1, 32'h0, lat, rdata, err, other, snap);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (!err || other || lat != 17 || timeout_count != 8'(exp_cnt)) bad++;
        end
        check("sat_sequence_bad", bad, 0);
        check("sat_count", timeout_count, 8'd255);

        // Reset pulse in the middle of a transfer.
        drive_master(0, 1'b1, 1'b0, 32'h80000020, 32'h0);
        cycle();
        cycle();
        check("pre_reset_busy", {s_bus.valid, busy}, 2'b11);
        resetn = 1'b0;
        drive_master(0, 1'b0, 1'b0, 32'h80000020, 32'h0);
        cycle();
        resetn = 1'b1;
        check("mid_reset_state", {s_bus.valid, busy, m0_bus.ready, m1_bus.ready, timeout_count}, '0);
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stray |= m0_bus.ready | m1_bus.ready | busy;
            cycle();
        end
        check("mid_reset_no_pulse", stray, 1'b0);

        do_xfer(1, 1'b0, 32'h80000024, 32'h0, 2, 32'hCAFE0001, lat, rdata, err, other, snap);
        check("post_reset_m1", {err, other, 8'(lat), rdata, grant_id}, {2'b00, 8'd3, 32'hCAFE0001, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
